// File: rtl/eth_ctrl_sequencer_if.sv
// Control-command handshake between the sequencer and the MAC example block.
//   control_data  : 4-bit command nibble (sequencer -> MAC)
//   control_valid : command valid        (sequencer -> MAC)
//   control_ready : MAC accepts command  (MAC -> sequencer)
// A command transfers on any clk cycle where control_valid and control_ready are both high.
interface eth_ctrl_sequencer_if;
    logic [3:0] control_data;
    logic       control_valid;
    logic       control_ready;

    modport master (
        output control_data,
        output control_valid,
        input  control_ready
    );

    modport slave (
        input  control_data,
        input  control_valid,
        output control_ready
    );
endinterface

// File: rtl/eth_ctrl_sequencer.sv
// eth_ctrl_sequencer
// Autonomous bring-up and monitoring stage in front of the Ethernet MAC example block.
// After reset or restart, the block runs these phases in order:
//   1. Waits STARTUP_CYCLES.
//   2. Pulses start_config for one cycle.
//   3. Waits CFG_SETTLE_CYCLES.
//   4. Issues NUM_CMDS command nibbles from CMD_LIST over a valid/ready handshake.
//   5. Enters MONITOR.
// It also counts rising edges of the MAC error and activity indications, with saturation.
// In MONITOR it flags a stalled link when no activity edge arrives for ACT_TIMEOUT cycles.
//
// Ports:
//   clk, sys_rst         : clock and synchronous active-high reset
//   restart              : pulse; reruns the sequence from START_WAIT (statistics kept)
//   clear_stats          : pulse; zeros counters, link_stalled and the idle timer
//   ctrl (master)        : control_data / control_valid / control_ready handshake
//   mtrlb_activity_flash : MAC activity level (toggles with traffic)
//   mtrlb_pktchk_error   : MAC packet-checker error level
//   start_config         : one-cycle configuration start pulse
//   seq_done             : high while in MONITOR
//   err_count, act_count : saturating rising-edge counts
//   link_stalled         : sticky idle-timeout flag
module eth_ctrl_sequencer #(
    parameter int unsigned STARTUP_CYCLES    = 1000,
    parameter int unsigned CFG_SETTLE_CYCLES = 64,
    parameter int unsigned NUM_CMDS          = 4,
    parameter logic [31:0] CMD_LIST          = 32'h0000_4321,
    parameter int unsigned ERR_CNT_W         = 8,
    parameter int unsigned ACT_TIMEOUT       = 100000
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   restart,
    input  logic                   clear_stats,
    eth_ctrl_sequencer_if.master   ctrl,
    input  logic                   mtrlb_activity_flash,
    input  logic                   mtrlb_pktchk_error,
    output logic                   start_config,
    output logic                   seq_done,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [ERR_CNT_W-1:0]   act_count,
    output logic                   link_stalled
);

    localparam int unsigned WAIT_MAX = (STARTUP_CYCLES > CFG_SETTLE_CYCLES) ?
                                       STARTUP_CYCLES : CFG_SETTLE_CYCLES;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned TMR_W    = $clog2(ACT_TIMEOUT + 1);

    localparam logic [WAIT_W-1:0] LAST_START  = WAIT_W'(STARTUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] LAST_SETTLE = WAIT_W'(CFG_SETTLE_CYCLES - 1);
    localparam logic [2:0]        LAST_IDX    = 3'(NUM_CMDS - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX     = TMR_W'(ACT_TIMEOUT);

    typedef enum logic [2:0] {
        START_WAIT,
        CFG_PULSE,
        SETTLE,
        CMD,
        MONITOR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        idx;
    logic [TMR_W-1:0]  idle_tmr;

    // One register stage per input, plus a history register for edge detection.
    logic act_cur, act_prev, err_cur, err_prev;
    logic act_rise, err_rise;

    assign act_rise = act_cur & ~act_prev;
    assign err_rise = err_cur & ~err_prev;

    function automatic logic [3:0] cmd_at(input logic [2:0] i);
        return CMD_LIST[{i, 2'b00} +: 4];
    endfunction

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state              <= START_WAIT;
            wait_cnt           <= '0;
            idx                <= '0;
            idle_tmr           <= '0;
            start_config       <= 1'b0;
            seq_done           <= 1'b0;
            ctrl.control_valid <= 1'b0;
            ctrl.control_data  <= 4'h0;
            err_count          <= '0;
            act_count          <= '0;
            link_stalled       <= 1'b0;
            act_cur            <= 1'b0;
            act_prev           <= 1'b0;
            err_cur            <= 1'b0;
            err_prev           <= 1'b0;
        end else begin
            act_cur  <= mtrlb_activity_flash;
            act_prev <= act_cur;
            err_cur  <= mtrlb_pktchk_error;
            err_prev <= err_cur;

            // start_config is only raised on the transition into CFG_PULSE.
            start_config <= 1'b0;

            if (restart) begin
                // Abandons any pending handshake; the MAC sees valid drop next cycle.
                state              <= START_WAIT;
                wait_cnt           <= '0;
                idx                <= '0;
                seq_done           <= 1'b0;
                ctrl.control_valid <= 1'b0;
                ctrl.control_data  <= 4'h0;
            end else begin
                case (state)
                    START_WAIT: begin
                        if (wait_cnt == LAST_START) begin
                            state        <= CFG_PULSE;
                            start_config <= 1'b1;
                            wait_cnt     <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    CFG_PULSE: begin
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (wait_cnt == LAST_SETTLE) begin
                            state              <= CMD;
                            wait_cnt           <= '0;
                            idx                <= '0;
                            ctrl.control_valid <= 1'b1;
                            ctrl.control_data  <= cmd_at(3'd0);
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    CMD: begin
                        // Data and valid only change once the current command is taken.
                        if (ctrl.control_ready) begin
                            if (idx == LAST_IDX) begin
                                state              <= MONITOR;
                                ctrl.control_valid <= 1'b0;
                                ctrl.control_data  <= 4'h0;
                                seq_done           <= 1'b1;
                                idle_tmr           <= '0;
                            end else begin
                                idx               <= idx + 3'd1;
                                ctrl.control_data <= cmd_at(idx + 3'd1);
                            end
                        end
                    end
                    MONITOR: begin
                        // Timer saturates at ACT_TIMEOUT; the flag is set as it gets there.
                        if (act_rise) begin
                            idle_tmr <= '0;
                        end else if (idle_tmr != TMR_MAX) begin
                            idle_tmr <= idle_tmr + TMR_W'(1);
                            if (idle_tmr == TMR_MAX - TMR_W'(1)) begin
                                link_stalled <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= START_WAIT;
                    end
                endcase
            end

            // Clearing wins over any edge seen in the same cycle.
            if (clear_stats) begin
                err_count    <= '0;
                act_count    <= '0;
                link_stalled <= 1'b0;
                idle_tmr     <= '0;
            end else begin
                if (err_rise && (err_count != '1)) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
                if (act_rise && (act_count != '1)) begin
                    act_count <= act_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/eth_ctrl_sequencer.md
Name: eth_ctrl_sequencer

Overview:
Autonomous control stage directly upstream of the Ethernet MAC example/support block. It replaces manual probe-driven configuration. After reset it pulses start_config, then issues a fixed list of 4-bit control commands over the control_valid/control_ready handshake. It then monitors the MAC's traffic-activity and packet-check-error indications, keeping saturating statistics and a stall flag.

Parameters:
STARTUP_CYCLES, 1000, cycles to wait after reset deassertion before start_config (min 1)
CFG_SETTLE_CYCLES, 64, cycles between start_config pulse and first command (min 1)
NUM_CMDS, 4, number of commands issued (1..8)
CMD_LIST, 32'h0000_4321, packed commands; entry i = CMD_LIST[4i+3:4i], issued i=0 first
ERR_CNT_W, 8, width of error and activity counters
ACT_TIMEOUT, 100000, cycles without an activity edge before link_stalled asserts (min 2)

Ports:
clk  input  1  single clock, same domain as the MAC control interface (axi_lite_clk)
sys_rst  input  1  synchronous, active-high reset
restart  input  1  one-cycle pulse; re-runs the sequence from START_WAIT
clear_stats  input  1  one-cycle pulse; zeros counters and clears link_stalled
control_ready  input  1  MAC accepts command when high with control_valid
mtrlb_activity_flash  input  1  MAC activity indicator (level, toggles with traffic)
mtrlb_pktchk_error  input  1  MAC packet-checker error (level)
start_config  output  1  one-cycle configuration start pulse
control_data  output  4  command nibble
control_valid  output  1  command valid
seq_done  output  1  high while in MONITOR
err_count  output  ERR_CNT_W  saturating count of pktchk_error rising edges
act_count  output  ERR_CNT_W  saturating count of activity_flash rising edges
link_stalled  output  1  sticky: no activity edge for ACT_TIMEOUT cycles in MONITOR

Behaviour:
- Reset (sys_rst high at a clk edge): state=START_WAIT with counter cleared. All outputs 0: start_config, control_data, control_valid, seq_done, counters, link_stalled. Edge-detect history regs are 0.
- States: START_WAIT -> CFG_PULSE -> SETTLE -> CMD -> MONITOR.
- START_WAIT: count STARTUP_CYCLES cycles, then -> CFG_PULSE.
- CFG_PULSE: start_config=1 for exactly this one cycle -> SETTLE.
- SETTLE: wait CFG_SETTLE_CYCLES cycles -> CMD with index=0.
- CMD: control_valid=1 and control_data=CMD_LIST entry[index]. Transfer occurs on a cycle with control_valid&control_ready. Data must stay stable while valid&!ready; valid must not drop before transfer. After a transfer, index increments. If index==NUM_CMDS-1, -> MONITOR with valid=0 the next cycle. Otherwise present the next command the next cycle; back-to-back transfers are allowed, 1 command/cycle max.
- MONITOR: seq_done=1. The idle timer counts cycles since the last activity rising edge or MONITOR entry. When the timer reaches ACT_TIMEOUT, link_stalled=1 (sticky). An activity edge restarts the timer but does not clear the flag.
- Edge detection: each input is registered once. A rising edge is cur&!prev, so a counter increments 1 cycle after the edge is seen.
- Counters: err_count and act_count count in all states after reset. They saturate at all-ones with no wrap.
- clear_stats: zeros both counters, link_stalled and the idle timer next cycle. An edge in the same cycle as clear_stats is dropped; counters read 0.
- restart: from any state -> START_WAIT next cycle. It drops control_valid and seq_done immediately, even mid-handshake. It does not clear the counters.
- restart and clear_stats both high: both take effect.
- sys_rst has priority over restart and clear_stats.
- control_ready is ignored outside CMD.

Test Plan:
1. STARTUP_CYCLES=10, CFG_SETTLE_CYCLES=4, ready tied 1 -> start_config pulse is 1 cycle wide at cycle 10 after reset. Commands 1,2,3,4 follow on 4 consecutive cycles. seq_done=1 on the following cycle.
2. ready low for 5 cycles during cmd index 1 -> control_data holds 2 and valid stays 1 throughout. Exactly 4 transfers total, no duplicates.
3. Drive 300 pktchk_error rising edges with ERR_CNT_W=8 -> err_count=255 and holds; clear_stats -> 0 next cycle.
4. In MONITOR with ACT_TIMEOUT=20: toggle activity every 10 cycles -> link_stalled stays 0. Stop the toggling -> link_stalled=1 after exactly 20 idle cycles and stays 1 when toggling resumes.
5. restart asserted while valid=1 with ready=0 at index 2 -> valid=0 next cycle, state is START_WAIT. The sequence reruns from command 1; err_count is preserved.
6. sys_rst asserted mid-MONITOR together with clear_stats -> all outputs are 0 next cycle and the sequence restarts from START_WAIT.
